// File: rtl/conv_stream_controller_pkg.sv
// Shared types, default configuration and width helpers for the convolver stream controller.
package conv_stream_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam int unsigned DEF_KERNEL_SIZE = 5;
    localparam int unsigned DEF_DATA_WIDTH  = 16;
    localparam int unsigned DEF_FRAC_BIT    = 8;
    localparam int unsigned DEF_IMAGE_W     = 28;
    localparam int unsigned DEF_IMAGE_H     = 28;
    localparam int unsigned DEF_DP_LATENCY  = 2;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned WADDR_W = cnt_w(DEF_KERNEL_SIZE * DEF_KERNEL_SIZE);
    localparam int unsigned ROW_W   = cnt_w(DEF_IMAGE_H);
    localparam int unsigned COL_W   = cnt_w(DEF_IMAGE_W);

endpackage

// File: rtl/conv_stream_controller_if.sv
// Input stream, datapath strobes and tagged-result signals of the convolver controller.
interface conv_stream_controller_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WADDR_W    = 5,
    parameter int unsigned ROW_W      = 5,
    parameter int unsigned COL_W      = 5
) ();
    logic                  start;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  dp_weight_write;
    logic [WADDR_W-1:0]    dp_weight_addr;
    logic                  dp_write;
    logic                  dp_row_end;
    logic                  out_valid;
    logic [ROW_W-1:0]      out_row;
    logic [COL_W-1:0]      out_col;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, in_data, in_valid,
        output in_ready, dp_weight_write, dp_weight_addr, dp_write, dp_row_end,
        output out_valid, out_row, out_col, busy, done
    );

    modport slave (
        output start, in_data, in_valid,
        input  in_ready, dp_weight_write, dp_weight_addr, dp_write, dp_row_end,
        input  out_valid, out_row, out_col, busy, done
    );
endinterface

// File: rtl/conv_stream_controller_valid_delay_line.sv
// Fixed-depth shift register that carries tags alongside a pipelined datapath.
module valid_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [DEPTH];

    // Advances every cycle; there is no stall input by design.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/conv_stream_controller.sv
// Sequences weight load and raster pixel streaming into the convolver datapath and
// tags each datapath result that comes from a fully populated window.
module conv_stream_controller
    import conv_stream_controller_pkg::*;
#(
    parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned FRAC_BIT    = DEF_FRAC_BIT,
    parameter int unsigned IMAGE_W     = DEF_IMAGE_W,
    parameter int unsigned IMAGE_H     = DEF_IMAGE_H,
    parameter int unsigned DP_LATENCY  = DEF_DP_LATENCY
) (
    input logic                      clk,
    input logic                      reset,
    conv_stream_controller_if.master bus
);
    localparam int unsigned TAPS   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned WCNT_W = cnt_w(TAPS);
    localparam int unsigned RCNT_W = cnt_w(IMAGE_H);
    localparam int unsigned CCNT_W = cnt_w(IMAGE_W);
    localparam int unsigned DCNT_W = cnt_w(DP_LATENCY);
    localparam int unsigned TAG_W  = 1 + RCNT_W + CCNT_W;

    generate
        if (IMAGE_W < KERNEL_SIZE || IMAGE_H < KERNEL_SIZE || DP_LATENCY < 1 ||
            FRAC_BIT > DATA_WIDTH) begin : g_bad_cfg
            $error("conv_stream_controller: unsupported parameter combination");
        end
    endgenerate

    state_t              state;
    logic [WCNT_W-1:0]   wcnt;
    logic [RCNT_W-1:0]   row;
    logic [CCNT_W-1:0]   col;
    logic [DCNT_W-1:0]   dcnt;

    logic                last_w_c;
    logic                last_col_c;
    logic                last_row_c;
    logic                last_drain_c;
    logic                win_full_c;
    logic [TAG_W-1:0]    tag_in_c;
    logic [TAG_W-1:0]    tag_out;

    assign last_w_c     = (wcnt == WCNT_W'(TAPS - 1));
    assign last_col_c   = (col == CCNT_W'(IMAGE_W - 1));
    assign last_row_c   = (row == RCNT_W'(IMAGE_H - 1));
    assign last_drain_c = (dcnt == DCNT_W'(DP_LATENCY - 1));
    assign win_full_c   = (row >= RCNT_W'(KERNEL_SIZE - 1)) && (col >= CCNT_W'(KERNEL_SIZE - 1));

    // Sequencer: state plus weight, raster and drain counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            wcnt  <= '0;
            row   <= '0;
            col   <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= LOAD_W;
                        wcnt  <= '0;
                    end
                end
                LOAD_W: begin
                    if (bus.in_valid) begin
                        if (last_w_c) begin
                            state <= STREAM;
                            wcnt  <= '0;
                            row   <= '0;
                            col   <= '0;
                        end else begin
                            wcnt <= wcnt + WCNT_W'(1);
                        end
                    end
                end
                STREAM: begin
                    if (bus.in_valid) begin
                        if (last_col_c) begin
                            col <= '0;
                            if (last_row_c) begin
                                state <= DRAIN;
                                row   <= '0;
                                dcnt  <= '0;
                            end else begin
                                row <= row + RCNT_W'(1);
                            end
                        end else begin
                            col <= col + CCNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + DCNT_W'(1);
                    if (last_drain_c) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes follow in_valid in the same cycle so the datapath captures in_data directly.
    always_comb begin
        bus.dp_weight_write = 1'b0;
        bus.dp_write        = 1'b0;
        bus.dp_row_end      = 1'b0;
        tag_in_c            = '0;
        if (state == LOAD_W && bus.in_valid) begin
            bus.dp_weight_write = 1'b1;
        end
        if (state == STREAM && bus.in_valid) begin
            bus.dp_write   = 1'b1;
            bus.dp_row_end = last_col_c;
            if (win_full_c) begin
                tag_in_c = {1'b1, row - RCNT_W'(KERNEL_SIZE - 1), col - CCNT_W'(KERNEL_SIZE - 1)};
            end
        end
    end

    valid_delay_line #(
        .WIDTH (TAG_W),
        .DEPTH (DP_LATENCY)
    ) u_tag_line (
        .clk   (clk),
        .rst_n (reset),
        .din   (tag_in_c),
        .dout  (tag_out)
    );

    assign bus.in_ready       = (state == LOAD_W) || (state == STREAM);
    assign bus.dp_weight_addr = wcnt;
    assign bus.busy           = (state != IDLE);
    assign bus.done           = (state == DONE);
    assign bus.out_valid      = tag_out[TAG_W-1];
    assign bus.out_row        = tag_out[CCNT_W +: RCNT_W];
    assign bus.out_col        = tag_out[0 +: CCNT_W];
endmodule

// File: tb/tb_conv_stream_controller.sv
// Scoreboard bench for conv_stream_controller: random stream stimulus, reference queues, decoupled monitor.
module tb_conv_stream_controller;
    import conv_stream_controller_pkg::*;

    localparam int unsigned K     = 5;
    localparam int unsigned W     = 8;
    localparam int unsigned H     = 8;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned WA    = cnt_w(K * K);
    localparam int unsigned RW    = cnt_w(H);
    localparam int unsigned CW    = cnt_w(W);
    localparam int unsigned N_OUT = (H - K + 1) * (W - K + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    conv_stream_controller_if #(.DATA_WIDTH(DW), .WADDR_W(WA), .ROW_W(RW), .COL_W(CW)) bus ();

    conv_stream_controller #(
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .FRAC_BIT    (8),
        .IMAGE_W     (W),
        .IMAGE_H     (H),
        .DP_LATENCY  (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int addr; int data; } wexp_t;
    typedef struct { int idx; int data; bit row_end; } pexp_t;
    typedef struct { int row; int col; int idx; } oexp_t;

    wexp_t wq[$];
    pexp_t pq[$];
    oexp_t oq[$];
    wexp_t we;
    pexp_t pe;
    oexp_t oe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cyc [W*H];
    int n_out = 0, n_rowend = 0, n_w = 0, n_done = 0;
    bit done_exp = 1'b0;
    bit prev_done = 1'b0;
    int vmode = 0;
    bit last_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT strobes or presents a result.
    always @(negedge clk) begin
        if (bus.dp_weight_write || bus.dp_write)
            check(bus.in_valid && bus.in_ready, "strobe_without_accept", int'(bus.in_ready), 1);
        if (bus.in_valid && bus.in_ready)
            check(bus.dp_weight_write ^ bus.dp_write, "accept_strobe", int'(bus.dp_write), 1);
        if (bus.dp_row_end)
            check(bus.dp_write, "row_end_without_write", int'(bus.dp_write), 1);
        if (!bus.busy)
            check(!bus.in_ready, "in_ready_when_idle", int'(bus.in_ready), 0);

        if (bus.dp_weight_write) begin
            check(wq.size() > 0, "unexpected_weight_write", int'(bus.dp_weight_addr), -1);
            if (wq.size() > 0) begin
                we = wq.pop_front();
                check(int'(bus.dp_weight_addr) == we.addr, "weight_addr", int'(bus.dp_weight_addr), we.addr);
                check(int'(bus.in_data) == we.data, "weight_data", int'(bus.in_data), we.data);
                n_w++;
            end
        end

        if (bus.dp_write) begin
            check(pq.size() > 0, "unexpected_dp_write", int'(bus.in_data), -1);
            if (pq.size() > 0) begin
                pe = pq.pop_front();
                check(int'(bus.in_data) == pe.data, "pixel_data", int'(bus.in_data), pe.data);
                check(bus.dp_row_end == pe.row_end, "dp_row_end", int'(bus.dp_row_end), int'(pe.row_end));
                wr_cyc[pe.idx] = cyc;
                if (bus.dp_row_end) n_rowend++;
            end
        end

        if (bus.out_valid) begin
            check(oq.size() > 0, "unexpected_out_valid", int'(bus.out_row), -1);
            if (oq.size() > 0) begin
                oe = oq.pop_front();
                check(int'(bus.out_row) == oe.row, "out_row", int'(bus.out_row), oe.row);
                check(int'(bus.out_col) == oe.col, "out_col", int'(bus.out_col), oe.col);
                check(cyc == wr_cyc[oe.idx] + int'(LAT), "out_latency", cyc - wr_cyc[oe.idx], int'(LAT));
                n_out++;
            end
        end else begin
            check(bus.out_row == '0 && bus.out_col == '0, "out_idx_zero_when_invalid",
                  int'(bus.out_row) * 100 + int'(bus.out_col), 0);
        end

        if (bus.done) begin
            check(done_exp, "unexpected_done", 1, int'(done_exp));
            check(oq.size() == 0, "done_before_last_output", oq.size(), 0);
            check(!prev_done, "done_width", 2, 1);
            done_exp = 1'b0;
            n_done++;
        end
        prev_done = bus.done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word with the current in_valid pattern and holds it until accepted.
    task automatic send(input int d, input bit st);
        bit ok;
        if (vmode == 1 && last_valid) begin
            bus.in_valid = 1'b0;
            tick();
        end else if (vmode == 2) begin
            while ($urandom_range(99) < 40) begin
                bus.in_valid = 1'b0;
                tick();
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(d);
        bus.start    = st;
        ok = 1'b0;
        for (int g = 0; g < 50 && !ok; g++) begin
            @(negedge clk);
            ok = bus.in_ready;
            if (!ok) tick();
        end
        check(ok, "in_ready_timeout", int'(ok), 1);
        tick();
        bus.start  = 1'b0;
        last_valid = 1'b1;
    endtask

    task automatic run_frame(input int mode, input bit rand_data, input bit pulse_start, input int abort_at);
        int o0, r0, w0, d0, d;
        bit got;
        vmode = mode;
        last_valid = 1'b0;
        o0 = n_out; r0 = n_rowend; w0 = n_w; d0 = n_done;

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check(bus.busy, "busy_after_start", int'(bus.busy), 1);

        for (int i = 0; i < int'(K * K); i++) begin
            d = rand_data ? int'($urandom_range(65535)) : 'h0100;
            wq.push_back('{i, d});
            send(d, pulse_start && i == 10);
        end

        for (int p = 0; p < int'(W * H); p++) begin
            int r, c;
            r = p / int'(W);
            c = p % int'(W);
            d = rand_data ? int'($urandom_range(65535)) : 'h0200;
            pq.push_back('{p, d, c == int'(W) - 1});
            if (r >= int'(K) - 1 && c >= int'(K) - 1)
                oq.push_back('{r - int'(K) + 1, c - int'(K) + 1, p});
            if (p == int'(W * H) - 1) done_exp = 1'b1;
            send(d, pulse_start && p == 20);
            if (p == abort_at) begin
                bus.in_valid = 1'b0;
                reset = 1'b0;
                tick();
                reset = 1'b1;
                wq.delete();
                pq.delete();
                oq.delete();
                done_exp = 1'b0;
                @(negedge clk);
                check(!bus.busy, "abort_busy", int'(bus.busy), 0);
                check(!bus.out_valid, "abort_out_valid", int'(bus.out_valid), 0);
                check(!bus.done, "abort_done", int'(bus.done), 0);
                check(!bus.in_ready, "abort_in_ready", int'(bus.in_ready), 0);
                repeat (6) tick();
                check(n_done == d0, "abort_no_done", n_done - d0, 0);
                return;
            end
        end

        // Keep offering data through drain and idle; nothing may be accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(16'hDEAD);
        got = 1'b0;
        for (int g = 0; g < 100 && !got; g++) begin
            @(negedge clk);
            got = bus.done;
        end
        check(got, "done_timeout", int'(got), 1);
        repeat (3) tick();
        bus.in_valid = 1'b0;

        check(n_out - o0 == int'(N_OUT), "frame_out_count", n_out - o0, int'(N_OUT));
        check(n_rowend - r0 == int'(H), "frame_row_end_count", n_rowend - r0, int'(H));
        check(n_w - w0 == int'(K * K), "frame_weight_count", n_w - w0, int'(K * K));
        check(n_done - d0 == 1, "frame_done_count", n_done - d0, 1);
        check(pq.size() == 0 && oq.size() == 0 && wq.size() == 0, "queues_drained",
              pq.size() + oq.size() + wq.size(), 0);
    endtask

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) tick();
        @(negedge clk);
        check(!bus.busy, "reset_busy", int'(bus.busy), 0);
        check(!bus.in_ready, "reset_in_ready", int'(bus.in_ready), 0);
        check(!bus.done, "reset_done", int'(bus.done), 0);
        check(!bus.out_valid, "reset_out_valid", int'(bus.out_valid), 0);
        check(bus.dp_weight_addr == '0, "reset_weight_addr", int'(bus.dp_weight_addr), 0);
        reset = 1'b1;
        tick();

        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        tick();

        run_frame(0, 1'b0, 1'b0, -1);
        run_frame(1, 1'b1, 1'b0, -1);
        run_frame(2, 1'b1, 1'b1, -1);
        run_frame(0, 1'b1, 1'b0, 40);
        run_frame(2, 1'b1, 1'b0, -1);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "bench timeout");
    end
endmodule
